// File: rtl/mem_arbiter_pkg.sv
// Shared typedefs for the VeriRisc core: opcodes, controller states and the
// memory-port arbiter states, plus the read-latency limit of the memory port.
package mem_arbiter_pkg;

    // Longest supported memory read latency, in cycles after the mem_rd cycle.
    localparam int RD_LAT_MAX = 3;
    // Width of the read-latency counter (must hold RD_LAT_MAX).
    localparam int LAT_CNT_W  = 2;

    typedef enum logic [2:0] {
        OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
    } state_t;

    typedef enum logic [1:0] {
        ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_DONE
    } arb_state_t;

    // Counter load value for a given read latency. Out-of-range latencies are
    // clamped into 1..RD_LAT_MAX so the wait state can never stall forever.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
        if (lat < 1) begin
            return LAT_CNT_W'(1);
        end else if (lat > RD_LAT_MAX) begin
            return LAT_CNT_W'(RD_LAT_MAX);
        end
        return LAT_CNT_W'(lat);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin picker. In normal mode any requester may win and ties
// go to the port that is not last_owner. With exclude_owner set, last_owner
// is the port currently being served and only the other port may win.
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    input  logic exclude_owner,
    output logic valid,
    output logic winner
);

    // Choose a winner from the request pair and the round-robin pointer.
    always_comb begin
        valid  = 1'b0;
        winner = 1'b0;
        if (exclude_owner) begin
            winner = ~last_owner;
            valid  = last_owner ? req0 : req1;
        end else if (req0 && req1) begin
            valid  = 1'b1;
            winner = ~last_owner;
        end else if (req0) begin
            valid  = 1'b1;
            winner = 1'b0;
        end else if (req1) begin
            valid  = 1'b1;
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single VeriRisc memory port between the CPU
// controller (port 0) and the loader/DMA path (port 1). One access at a time:
// IDLE -> ACCESS -> (WAIT for reads) -> DONE, with a direct hand-over from
// DONE to the other port when it is waiting. All outputs are registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DWIDTH-1:0] rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DWIDTH-1:0] mem_rdata
);

    arb_state_t             state_reg, state_next;
    logic                   owner_reg, owner_next;
    logic                   last_owner_reg, last_owner_next;
    logic                   we_reg, we_next;
    logic [LAT_CNT_W-1:0]   cnt_reg, cnt_next;
    logic                   gnt0_reg, gnt0_next;
    logic                   gnt1_reg, gnt1_next;
    logic                   ack0_reg, ack0_next;
    logic                   ack1_reg, ack1_next;
    logic [DWIDTH-1:0]      rdata_reg, rdata_next;
    logic [AWIDTH-1:0]      mem_addr_reg, mem_addr_next;
    logic [DWIDTH-1:0]      mem_wdata_reg, mem_wdata_next;
    logic                   mem_rd_reg, mem_rd_next;
    logic                   mem_wr_reg, mem_wr_next;

    logic                   pick_excl;
    logic                   pick_last;
    logic                   pick_valid;
    logic                   pick_winner;
    logic                   do_grant;
    logic                   win_we;
    logic [AWIDTH-1:0]      win_addr;
    logic [DWIDTH-1:0]      win_wdata;

    // In DONE the pointer handed to the picker is the current owner, so only
    // the other port can take over without going back through IDLE.
    assign pick_excl = (state_reg == ARB_DONE);
    assign pick_last = pick_excl ? owner_reg : last_owner_reg;

    rr_pick u_pick (
        .req0          (req0),
        .req1          (req1),
        .last_owner    (pick_last),
        .exclude_owner (pick_excl),
        .valid         (pick_valid),
        .winner        (pick_winner)
    );

    assign win_we    = pick_winner ? we1    : we0;
    assign win_addr  = pick_winner ? addr1  : addr0;
    assign win_wdata = pick_winner ? wdata1 : wdata0;

    // Next-state and next-output logic; strobes and acks default to idle.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        we_next         = we_reg;
        cnt_next        = cnt_reg;
        gnt0_next       = gnt0_reg;
        gnt1_next       = gnt1_reg;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;
        rdata_next      = rdata_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_rd_next     = 1'b0;
        mem_wr_next     = 1'b0;
        do_grant        = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                do_grant = pick_valid;
            end
            ARB_ACCESS: begin
                if (we_reg) begin
                    ack0_next  = ~owner_reg;
                    ack1_next  = owner_reg;
                    state_next = ARB_DONE;
                end else begin
                    cnt_next   = lat_load(RD_LAT);
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (cnt_reg <= LAT_CNT_W'(1)) begin
                    rdata_next = mem_rdata;
                    ack0_next  = ~owner_reg;
                    ack1_next  = owner_reg;
                    state_next = ARB_DONE;
                end else begin
                    cnt_next = cnt_reg - LAT_CNT_W'(1);
                end
            end
            ARB_DONE: begin
                last_owner_next = owner_reg;
                do_grant        = pick_valid;
                if (!pick_valid) begin
                    gnt0_next  = 1'b0;
                    gnt1_next  = 1'b0;
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        // A grant latches the winner's request and pre-loads the strobes so
        // they are already registered during the ACCESS cycle.
        if (do_grant) begin
            state_next    = ARB_ACCESS;
            owner_next    = pick_winner;
            we_next       = win_we;
            gnt0_next     = ~pick_winner;
            gnt1_next     = pick_winner;
            mem_addr_next = win_addr;
            mem_wr_next   = win_we;
            mem_rd_next   = ~win_we;
            if (win_we) begin
                mem_wdata_next = win_wdata;
            end
        end
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            we_reg         <= 1'b0;
            cnt_reg        <= '0;
            gnt0_reg       <= 1'b0;
            gnt1_reg       <= 1'b0;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
            rdata_reg      <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_rd_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            we_reg         <= we_next;
            cnt_reg        <= cnt_next;
            gnt0_reg       <= gnt0_next;
            gnt1_reg       <= gnt1_next;
            ack0_reg       <= ack0_next;
            ack1_reg       <= ack1_next;
            rdata_reg      <= rdata_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_rd_reg     <= mem_rd_next;
            mem_wr_reg     <= mem_wr_next;
        end
    end

    assign gnt0      = gnt0_reg;
    assign gnt1      = gnt1_reg;
    assign ack0      = ack0_reg;
    assign ack1      = ack1_reg;
    assign rdata     = rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with RD_LAT=1 driven through all
// directed scenarios, and one with RD_LAT=3 for the long-latency read.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A (RD_LAT = 1)
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [4:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic       gnt0, gnt1, ack0, ack1, mem_rd, mem_wr;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;

    // Instance B (RD_LAT = 3)
    logic       req0_b = 0, req1_b = 0, we0_b = 0, we1_b = 0;
    logic [4:0] addr0_b = 0, addr1_b = 0;
    logic [7:0] wdata0_b = 0, wdata1_b = 0;
    logic       gnt0_b, gnt1_b, ack0_b, ack1_b, mem_rd_b, mem_wr_b;
    logic [7:0] rdata_b, mem_wdata_b, mem_rdata_b;
    logic [4:0] mem_addr_b;

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
        .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rd(mem_rd_b),
        .mem_wr(mem_wr_b), .mem_rdata(mem_rdata_b)
    );

    function automatic logic [7:0] preload(input int i);
        if (i == 3) return 8'hA5;
        return 8'(i * 17 + 90);
    endfunction

    // Memory models: data appears RD_LAT cycles after the mem_rd cycle and is
    // only valid for that one cycle (8'hEE otherwise).
    logic [7:0] mem_a [0:31];
    logic [7:0] pd_a;
    logic       pv_a;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem_a[i] <= preload(i);
        end else if (mem_wr) begin
            mem_a[mem_addr] <= mem_wdata;
        end
        pd_a <= mem_a[mem_addr];
        pv_a <= mem_rd;
    end
    assign mem_rdata = pv_a ? pd_a : 8'hEE;

    logic [7:0] mem_b [0:31];
    logic [7:0] pd_b [0:2];
    logic       pv_b [0:2];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem_b[i] <= preload(i);
        end else if (mem_wr_b) begin
            mem_b[mem_addr_b] <= mem_wdata_b;
        end
        pd_b[0] <= mem_b[mem_addr_b];
        pv_b[0] <= mem_rd_b;
        pd_b[1] <= pd_b[0];
        pv_b[1] <= pv_b[0];
        pd_b[2] <= pd_b[1];
        pv_b[2] <= pv_b[1];
    end
    assign mem_rdata_b = pv_b[2] ? pd_b[2] : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for instance A: reference memory, access order log, and
    // per-cycle rule checks derived from the requesters' own transactions.
    logic [7:0] ref_mem [0:31];
    logic [7:0] prev_rdata;
    int         ack_log [$];

    initial begin
        logic p;
        for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);
        prev_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("reset_ctrl", 32'({gnt0, gnt1, ack0, ack1, mem_rd, mem_wr}), 32'd0);
                chk("reset_data", 32'({rdata, mem_addr, mem_wdata}), 32'd0);
            end else begin
                chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
                chk("ack_excl", 32'(ack0 & ack1), 32'd0);
                chk("strobe_excl", 32'(mem_rd & mem_wr), 32'd0);
                if (mem_rd || mem_wr) begin
                    p = gnt1;
                    chk("strobe_gnt", 32'(gnt0 | gnt1), 32'd1);
                    chk("strobe_addr", 32'(mem_addr), 32'(p ? addr1 : addr0));
                    chk("strobe_dir", 32'(mem_wr), 32'(p ? we1 : we0));
                    if (mem_wr) chk("strobe_wdata", 32'(mem_wdata), 32'(p ? wdata1 : wdata0));
                end
                if (ack0 || ack1) begin
                    p = ack1;
                    chk("ack_gnt", 32'(p ? gnt1 : gnt0), 32'd1);
                    chk("ack_req", 32'(p ? req1 : req0), 32'd1);
                    if (p ? we1 : we0) begin
                        ref_mem[p ? addr1 : addr0] = p ? wdata1 : wdata0;
                        chk("wr_rdata_hold", 32'(rdata), 32'(prev_rdata));
                    end else begin
                        chk("rd_data", 32'(rdata), 32'(ref_mem[p ? addr1 : addr0]));
                    end
                    ack_log.push_back(int'(p));
                end else begin
                    chk("rdata_hold", 32'(rdata), 32'(prev_rdata));
                end
            end
            prev_rdata = rdata;
        end
    end

    // One access on instance A. lat counts edges from the request up to and
    // including the edge at which the requester samples ack high.
    task automatic access(input int p, input logic w, input logic [4:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd, output int strobes);
        bit done;
        done = 0;
        lat = 0;
        rd = '0;
        strobes = 0;
        if (p == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
        else        begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) strobes++;
            if ((p == 0) ? ack0 : ack1) begin
                lat = n + 1;
                rd = rdata;
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout port %0d: no ack within 40 cycles, required ack", p);
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    logic       t0_we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] t0_a  [4] = '{5'h10, 5'h10, 5'h12, 5'h11};
    logic [7:0] t0_d  [4] = '{8'h11, 8'h00, 8'h22, 8'h00};
    logic [7:0] t0_x  [4] = '{8'h00, 8'h11, 8'h00, 8'h33};
    logic       t1_we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0] t1_a  [4] = '{5'h10, 5'h11, 5'h12, 5'h03};
    logic [7:0] t1_d  [4] = '{8'h00, 8'h33, 8'h00, 8'h00};
    logic [7:0] t1_x  [4] = '{8'h11, 8'h00, 8'h22, 8'hA5};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0, l1, s0, s1, lb;
        logic [7:0] r0, r1, rb;
        bit done_b;

        // Reset and idle
        @(negedge clk);
        mem_init = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("idle_strobes", 32'({mem_rd, mem_wr}), 32'd0);

        // Single write by port 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h03; wdata0 = 8'hA5;
        @(negedge clk);
        chk("t1_mem_wr", 32'(mem_wr), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h03);
        chk("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
        chk("t1_gnt0", 32'(gnt0), 32'd1);
        chk("t1_ack0_early", 32'(ack0), 32'd0);
        @(negedge clk);
        chk("t1_mem_wr_off", 32'(mem_wr), 32'd0);
        chk("t1_ack0", 32'(ack0), 32'd1);
        chk("t1_gnt1", 32'(gnt1), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        chk("t1_ack0_pulse", 32'(ack0), 32'd0);
        chk("t1_gnt0_drop", 32'(gnt0), 32'd0);

        // Single read by port 1, RD_LAT=1
        access(1, 1'b0, 5'h03, 8'h00, l1, r1, s1);
        chk("t2_lat", 32'(l1), 32'd4);
        chk("t2_rdata", 32'(r1), 32'hA5);
        chk("t2_strobes", 32'(s1), 32'd1);
        @(negedge clk);
        chk("t2_rdata_held", 32'(rdata), 32'hA5);

        // Read on the RD_LAT=3 instance
        req1_b = 1'b1; we1_b = 1'b0; addr1_b = 5'h03;
        done_b = 0; lb = 0; rb = '0;
        for (int n = 1; n <= 40 && !done_b; n++) begin
            @(negedge clk);
            if (ack1_b) begin lb = n + 1; rb = rdata_b; done_b = 1; end
        end
        req1_b = 1'b0;
        chk("t2b_lat", 32'(lb), 32'd6);
        chk("t2b_rdata", 32'(rb), 32'hA5);

        // Simultaneous writes right after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack_log.delete();
        fork
            access(0, 1'b1, 5'h08, 8'h3C, l0, r0, s0);
            access(1, 1'b1, 5'h09, 8'hC3, l1, r1, s1);
        join
        chk("t3_lat0", 32'(l0), 32'd3);
        chk("t3_lat1", 32'(l1), 32'd5);
        chk("t3_nacks", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            chk("t3_order0", 32'(ack_log[0]), 32'd0);
            chk("t3_order1", 32'(ack_log[1]), 32'd1);
        end
        @(negedge clk);

        // Both ports continuously busy for 8 accesses
        ack_log.delete();
        fork
            begin
                int l; int s; logic [7:0] r;
                for (int k = 0; k < 4; k++) begin
                    access(0, t0_we[k], t0_a[k], t0_d[k], l, r, s);
                    if (!t0_we[k]) chk("t4_rd_port0", 32'(r), 32'(t0_x[k]));
                end
            end
            begin
                int l; int s; logic [7:0] r;
                for (int k = 0; k < 4; k++) begin
                    access(1, t1_we[k], t1_a[k], t1_d[k], l, r, s);
                    if (!t1_we[k]) chk("t4_rd_port1", 32'(r), 32'(t1_x[k]));
                end
            end
        join
        chk("t4_nacks", 32'(ack_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < ack_log.size(); k++) begin
            chk("t4_alternate", 32'(ack_log[k]), 32'(k % 2));
        end
        repeat (2) @(negedge clk);

        // Reset in the middle of a read
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h12;
        @(negedge clk);
        chk("t5_mem_rd", 32'(mem_rd), 32'd1);
        chk("t5_gnt1", 32'(gnt1), 32'd1);
        @(negedge clk);
        chk("t5_wait_gnt1", 32'(gnt1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ctrl", 32'({gnt0, gnt1, ack0, ack1, mem_rd}), 32'd0);
        chk("t5_rst_state", 32'(u_dut.state_reg), 32'(ARB_IDLE));
        @(negedge clk);
        chk("t5_rst_noack", 32'({ack0, ack1}), 32'd0);
        rst = 1'b0;
        ack_log.delete();
        fork
            access(0, 1'b1, 5'h05, 8'h5C, l0, r0, s0);
            access(1, 1'b0, 5'h12, 8'h00, l1, r1, s1);
        join
        chk("t5_lat0", 32'(l0), 32'd3);
        chk("t5_lat1", 32'(l1), 32'd6);
        chk("t5_rd1", 32'(r1), 32'h22);
        chk("t5_nacks", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) chk("t5_first", 32'(ack_log[0]), 32'd0);
        @(negedge clk);

        // Port 0 alone, three consecutive reads
        access(0, 1'b0, 5'h05, 8'h00, l0, r0, s0);
        chk("t6_lat_first", 32'(l0), 32'd4);
        chk("t6_rd_first", 32'(r0), 32'h5C);
        access(0, 1'b0, 5'h08, 8'h00, l0, r0, s0);
        chk("t6_spacing2", 32'(l0 - 1), 32'd4);
        chk("t6_rd_second", 32'(r0), 32'h3C);
        access(0, 1'b0, 5'h09, 8'h00, l0, r0, s0);
        chk("t6_spacing3", 32'(l0 - 1), 32'd4);
        chk("t6_rd_third", 32'(r0), 32'hC3);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single VeriRisc memory port between the CPU controller path (requester 0) and a loader/DMA path (requester 1).
- Each requester has its own req/ack handshake. The arbiter grants one owner per access using round-robin priority.
- It drives mem_rd/mem_wr, the address and the write data to the memory, and returns the read data to the owner.
- It sits between the control/datapath and the memory, so the memory block itself stays single-ported.

Parameters:
- AWIDTH, 5, address width.
- DWIDTH, 8, data width.
- RD_LAT, 1, cycles from the mem_rd cycle to valid mem_rdata (legal range 1-3).

Ports:
- clk  in  1  clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request.
- we0, we1  in  1  1 = write, 0 = read; sampled at grant.
- addr0, addr1  in  AWIDTH  access address; sampled at grant.
- wdata0, wdata1  in  DWIDTH  write data; sampled at grant.
- gnt0, gnt1  out  1  requester currently owns the memory.
- ack0, ack1  out  1  one-cycle pulse: access complete.
- rdata  out  DWIDTH  read data; valid only in the owner's ack cycle.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DWIDTH  memory read data.

Behaviour:
- All outputs are registered.
- Reset values: gnt*=0, ack*=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, state=ARB_IDLE, last_owner=1 (so port 0 wins first).
- States are ARB_IDLE, ARB_ACCESS, ARB_WAIT and ARB_DONE.
- ARB_IDLE:
  - If no req, stay in ARB_IDLE.
  - If exactly one req, grant it.
  - If both req, grant the port that is not last_owner.
  - On grant: latch we/addr/wdata of the winner, set its gnt, go to ARB_ACCESS.
- ARB_ACCESS (exactly 1 cycle):
  - mem_addr is the latched address.
  - Write: mem_wr=1, mem_wdata = latched data, then go to ARB_DONE.
  - Read: mem_rd=1, load the latency counter with RD_LAT, then go to ARB_WAIT.
  - mem_rd and mem_wr are never both 1.
- ARB_WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into rdata and go to ARB_DONE.
  - With RD_LAT=1 this takes exactly 1 cycle.
- ARB_DONE (1 cycle):
  - Owner's ack=1 and gnt stays 1.
  - last_owner is updated to the current owner.
  - If the other port's req=1, grant it directly (latch its fields, go to ARB_ACCESS, gnt switches on the next edge).
  - Otherwise drop gnt and go to ARB_IDLE.
  - The owner's own req is ignored in ARB_DONE. A held req is re-arbitrated from ARB_IDLE.
- Latency from req seen in ARB_IDLE to ack:
  - Write: 3 edges (IDLE→ACCESS→DONE).
  - Read: 3+RD_LAT edges.
  - Back-to-back accesses by alternating ports skip ARB_IDLE.
- Requester rules:
  - Hold req until ack; drop req in the cycle after ack or re-request.
  - we/addr/wdata must be valid whenever req=1. The arbiter uses only the values sampled at grant.
  - Dropping req before ack is illegal; the access completes regardless.
- Exclusivity: gnt0 and gnt1 are never both 1; ack0 and ack1 are never both 1.
- rdata holds its last value outside ack. For write accesses rdata is unchanged.
- Reset mid-operation (rst high in any state): on the next edge the block returns to reset values. The in-flight access gets no ack, and any pending mem strobe is deasserted.
- Reset has priority over all other inputs.

Decomposition:
- Add arb_state_t (enum logic [1:0]: ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_DONE) to the shared typedefs package alongside opcode_t/state_t.
- Add the RD_LAT maximum constant to the same package.
- One sub-module: rr_pick. It is combinational: inputs req0, req1, last_owner, exclude_owner; outputs valid and winner.

Test Plan:
- Reset, then req0=1, we0=1, addr0=5'h03, wdata0=8'hA5 → mem_wr=1 with mem_addr=03 and mem_wdata=A5 for one cycle; ack0 pulses 1 cycle later; gnt1 stays 0.
- Memory model preloaded with [03]=8'hA5, RD_LAT=1, req1 read at addr1=03 → mem_rd for 1 cycle; ack1 with rdata=A5 on the 4th edge after req1 is seen. Repeat with RD_LAT=3 → ack on the 6th edge.
- req0 and req1 both write-asserted in the same cycle after reset → port 0 is served first; port 1 is granted directly from ARB_DONE without passing ARB_IDLE; both acks arrive within 6 edges.
- Both reqs held continuously for 8 accesses → grants strictly alternate 0,1,0,1,…; gnt0&gnt1 is never 1; mem_rd&mem_wr is never 1.
- rst=1 asserted during ARB_WAIT of a read → next edge gives mem_rd=0, gnt*=0, no ack*, state ARB_IDLE. After release, a pending req1 is served only after a pending req0 (last_owner reset to 1).
- Only req0 held high for 3 consecutive reads → each access re-passes ARB_IDLE, spacing acks 4 cycles apart with RD_LAT=1.
